// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel frame capture with a one-word hold handshake.
// Define SERIAL_NEG_EN to negate (two's complement) each frame as it arrives.
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             sign,
  output logic             zero,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-2:0] sreg;
  logic             d;
  logic             last;
  logic             go;

`ifdef SERIAL_NEG_EN
  // Negation flips every bit after the first 1 seen in the frame
  logic seen_one;
  assign d = a ^ seen_one;
`else
  assign d = a;
`endif

  assign last = (count == CW'(WIDTH - 1));
  assign go   = start & ((state == IDLE) | (state == SHIFT) |
                         ((state == HOLD) & out_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      sign       <= 1'b0;
      zero       <= 1'b1;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_NEG_EN
      seen_one   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= SHIFT;
        end
        SHIFT: begin
          if (start) begin
            frame_err <= 1'b1;
          end else if (last) begin
            state      <= HOLD;
            word       <= {d, sreg};
            sign       <= d;
            zero       <= ~d & ~|sreg;
            word_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            word_valid <= 1'b0;
            state      <= start ? SHIFT : IDLE;
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Bit 0 of a frame never sees an earlier 1, so it is always raw a
      if (go) begin
        sreg  <= (WIDTH-1)'(a);
        count <= CW'(1);
`ifdef SERIAL_NEG_EN
        seen_one <= a;
`endif
      end else if (state == SHIFT) begin
        if (last) begin
          count <= '0;
        end else begin
          sreg  <= sreg | ((WIDTH-1)'(d) << count);
          count <= count + CW'(1);
        end
`ifdef SERIAL_NEG_EN
        seen_one <= seen_one | a;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// Directed plus random frames for serial_deser against an arithmetic model.
// Build with SERIAL_NEG_EN defined to check the negating variant.
module tb_serial_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         a = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] word;
  logic         word_valid;
  logic         sign;
  logic         zero;
  logic         frame_err;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_word = '0;
  logic         exp_ferr = 1'b0;
  logic         exp_ovr = 1'b0;

  serial_deser #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .out_ready(out_ready),
    .word(word),
    .word_valid(word_valid),
    .sign(sign),
    .zero(zero),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] v);
`ifdef SERIAL_NEG_EN
    return W'(0) - v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      start = (i == 0);
      a     = v[i];
      step();
      if (i < W - 1) begin
        chk("busy_valid", 32'(word_valid), 32'd0);
        chk("word_stable", 32'(word), 32'(last_word));
      end
    end
    start = 1'b0;
    a     = 1'b0;
  endtask

  task automatic finish_frame(input logic [W-1:0] v);
    logic [W-1:0] e;
    e = model(v);
    chk("valid", 32'(word_valid), 32'd1);
    chk("word", 32'(word), 32'(e));
    chk("sign", 32'(sign), 32'(e[W-1]));
    chk("zero", 32'(zero), 32'(e == '0));
    chk("frame_err", 32'(frame_err), 32'(exp_ferr));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    last_word = e;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    start     = 1'b0;
    step();
    chk("consumed", 32'(word_valid), 32'd0);
    chk("word_kept", 32'(word), 32'(last_word));
  endtask

  task automatic chk_reset();
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
  endtask

  initial begin
    logic [W-1:0] v;
    int gap;

    step();
    step();
    reset = 1'b0;
    chk_reset();

    // Idle bits without start must be ignored
    a = 1'b1;
    step();
    step();
    a = 1'b0;
    chk("idle_valid", 32'(word_valid), 32'd0);

    out_ready = 1'b1;
    send(8'h05, W);
    finish_frame(8'h05);
    consume();

    send(8'h00, W);
    finish_frame(8'h00);
    consume();

    send(8'h80, W);
    finish_frame(8'h80);
    consume();

    // Abort after four bits, then a complete 0x3C
    send(8'hFF, 4);
    send(8'h3C, W);
    exp_ferr = 1'b1;
    finish_frame(8'h3C);
    consume();

    // Held word with a dropped start, then back-to-back accept
    out_ready = 1'b0;
    send(8'hA7, W);
    finish_frame(8'hA7);
    start = 1'b1;
    a     = 1'b1;
    step();
    start = 1'b0;
    exp_ovr = 1'b1;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(word_valid), 32'd1);
    chk("ovr_word", 32'(word), 32'(last_word));
    step();
    chk("ovr_hold", 32'(word_valid), 32'd1);
    out_ready = 1'b1;
    send(8'h6B, W);
    finish_frame(8'h6B);
    consume();

    // Reset mid-frame
    send(8'hA5, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    last_word = '0;
    chk_reset();
    send(8'h5A, W);
    finish_frame(8'h5A);
    consume();

    for (int k = 0; k < 25; k++) begin
      v   = W'($urandom);
      gap = $urandom_range(3);
      for (int g = 0; g < gap; g++) begin
        a = 1'($urandom);
        step();
      end
      a = 1'b0;
      send(v, W);
      finish_frame(v);
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
